// File: rtl/fp_div_serial_top.sv
// ---------------------------------------------------------------------------
// fp_div_serial_top
//
// Byte-serial divider wrapper. Eight input bytes carry a 32-bit dividend Z
// and a 32-bit divisor D, MSB first. Each complete word goes into a small
// FIFO. An iterative divider takes words from the FIFO one at a time.
// It divides either as IEEE-754 fp32 (select=1) or as 32-bit integers
// (select=0, with sign choosing signed or unsigned). The 64-bit result is
// streamed back as eight bytes, LSB byte first.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset; aborts everything
//   push_in       input byte valid
//   data_in_in    input byte
//   sign          integer mode: 1=signed, 0=unsigned (sampled with byte 8)
//   select        0=integer divide, 1=fp32 divide (sampled with byte 8)
//   data_out_out  output byte (0 when not streaming)
//   pull_out      one-cycle pulse marking the first output byte
//   sign_out      result bit 63, held while streaming (0 otherwise)
//
// Configuration macro
//   FP_ROUND_NEAREST_EN  when defined, the fp mantissa is rounded to
//                        nearest-even instead of truncated.
// ---------------------------------------------------------------------------
module fp_div_serial_top #(
    parameter int DATA_WIDTH       = 65,
    parameter int BUFFER_DEPTH     = 4,
    parameter int LOG_BUFFER_DEPTH = 3,
    parameter int WIDTH            = 32,
    parameter int EXPWIDTH         = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_in,
    input  logic [7:0] data_in_in,
    input  logic       sign,
    input  logic       select,
    output logic [7:0] data_out_out,
    output logic       pull_out,
    output logic       sign_out
);

    localparam int AW        = LOG_BUFFER_DEPTH - 1;
    localparam int STEPS     = 4;
    // 28 fp steps give 24 mantissa bits plus 4 bits for rounding.
    localparam int FP_ITERS  = 7;
    localparam int INT_ITERS = WIDTH / STEPS;

    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;
    localparam logic [1:0] SP_ZERO = 2'd3;

    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

    // ---------------- input assembly and FIFO ----------------
    logic [2:0]              byte_cnt_q, byte_cnt_d;
    logic [55:0]             in_shift_q, in_shift_d;
    logic [DATA_WIDTH:0]     fifo_mem_q [BUFFER_DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                    fifo_wr, fifo_rd, fifo_empty, fifo_full;
    logic [DATA_WIDTH:0]     fifo_wdata, head_entry;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_entry = fifo_mem_q[rd_ptr_q[AW-1:0]];

    // The eighth byte completes the word. If the FIFO is full, the word is
    // dropped, but the byte counter still wraps.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        in_shift_d = in_shift_q;
        fifo_wr    = 1'b0;
        fifo_wdata = {select, sign, in_shift_q, data_in_in};
        if (push_in) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            in_shift_d = {in_shift_q[47:0], data_in_in};
            if (byte_cnt_q == 3'd7) begin
                fifo_wr = !fifo_full;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (fifo_wr) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= fifo_wdata;
        end
    end

    // ---------------- operand preparation from the FIFO head ----------------
    logic             head_sel, head_sgn;
    logic [WIDTH-1:0] head_z, head_d;
    logic             z_neg, d_neg;
    logic [WIDTH-1:0] z_abs, d_abs;
    logic [23:0]      mant_z, mant_d;
    logic             mant_lt;
    logic [24:0]      fp_x;
    logic [9:0]       exp_pre;
    logic [1:0]       special_pre;

    assign head_sel = head_entry[DATA_WIDTH];
    assign head_sgn = head_entry[DATA_WIDTH-1];
    assign head_z   = head_entry[2*WIDTH-1:WIDTH];
    assign head_d   = head_entry[WIDTH-1:0];

    // For fp, the smaller dividend mantissa is pre-doubled so the quotient
    // lands in [1,2). The divider is then seeded with half of it, so that
    // its first shift reproduces the full value.
    always_comb begin
        z_neg   = head_sgn & head_z[WIDTH-1];
        d_neg   = head_sgn & head_d[WIDTH-1];
        z_abs   = z_neg ? -head_z : head_z;
        d_abs   = d_neg ? -head_d : head_d;
        mant_z  = {1'b1, head_z[22:0]};
        mant_d  = {1'b1, head_d[22:0]};
        mant_lt = (mant_z < mant_d);
        fp_x    = mant_lt ? {mant_z, 1'b0} : {1'b0, mant_z};
        exp_pre = {2'b00, head_z[30:23]} - {2'b00, head_d[30:23]} + 10'd127
                  - {9'd0, mant_lt};
        special_pre = SP_NONE;
        if ((head_z[30:23] == 8'hFF && head_z[22:0] != 23'd0) ||
            (head_d[30:23] == 8'hFF && head_d[22:0] != 23'd0)) begin
            special_pre = SP_NAN;
        end else if (head_d[30:23] == 8'd0) begin
            special_pre = SP_INF;
        end else if (head_z[30:23] == 8'd0) begin
            special_pre = SP_ZERO;
        end else if ($signed(exp_pre) > 10'sd254) begin
            special_pre = SP_INF;
        end else if ($signed(exp_pre) < 10'sd1) begin
            special_pre = SP_ZERO;
        end
    end

    // ---------------- iterative restoring divider ----------------
    div_state_t          state_q, state_d;
    logic [EXPWIDTH-1:0] iter_q, iter_d;
    logic [WIDTH-1:0]    rem_q, rem_d, num_q, num_d, den_q, den_d, quo_q, quo_d;
    logic [WIDTH-1:0]    orig_z_q, orig_z_d;
    logic                fp_mode_q, fp_mode_d, res_sign_q, res_sign_d;
    logic                q_neg_q, q_neg_d, r_neg_q, r_neg_d, div_zero_q, div_zero_d;
    logic [7:0]          exp_q, exp_d;
    logic [1:0]          special_q, special_d;
    logic [WIDTH-1:0]    step_rem, step_num, step_quo;
    logic [WIDTH:0]      step_trial;
    logic                out_load, out_idle;

    // Several shift-compare-subtract steps per clock. Each step pulls the next
    // dividend bit into the partial remainder.
    always_comb begin
        step_rem   = rem_q;
        step_num   = num_q;
        step_quo   = quo_q;
        step_trial = '0;
        for (int k = 0; k < STEPS; k++) begin
            step_trial = {step_rem, step_num[WIDTH-1]};
            step_num   = {step_num[WIDTH-2:0], 1'b0};
            if (step_trial >= {1'b0, den_q}) begin
                step_trial = step_trial - {1'b0, den_q};
                step_quo   = {step_quo[WIDTH-2:0], 1'b1};
            end else begin
                step_quo   = {step_quo[WIDTH-2:0], 1'b0};
            end
            step_rem = step_trial[WIDTH-1:0];
        end
    end

    // The divider holds its finished result in DIV_DONE until the output
    // streamer is free.
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        rem_d      = rem_q;
        num_d      = num_q;
        den_d      = den_q;
        quo_d      = quo_q;
        orig_z_d   = orig_z_q;
        fp_mode_d  = fp_mode_q;
        res_sign_d = res_sign_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        exp_d      = exp_q;
        special_d  = special_q;
        fifo_rd    = 1'b0;
        out_load   = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd    = 1'b1;
                    state_d    = DIV_CALC;
                    fp_mode_d  = head_sel;
                    quo_d      = '0;
                    orig_z_d   = head_z;
                    res_sign_d = head_z[WIDTH-1] ^ head_d[WIDTH-1];
                    q_neg_d    = z_neg ^ d_neg;
                    r_neg_d    = z_neg;
                    div_zero_d = (head_d == '0);
                    exp_d      = exp_pre[7:0];
                    special_d  = special_pre;
                    if (head_sel) begin
                        iter_d = EXPWIDTH'(FP_ITERS);
                        rem_d  = {{(WIDTH-24){1'b0}}, fp_x[24:1]};
                        num_d  = {fp_x[0], {(WIDTH-1){1'b0}}};
                        den_d  = {{(WIDTH-24){1'b0}}, mant_d};
                    end else begin
                        iter_d = EXPWIDTH'(INT_ITERS);
                        rem_d  = '0;
                        num_d  = z_abs;
                        den_d  = d_abs;
                    end
                end
            end
            DIV_CALC: begin
                rem_d  = step_rem;
                num_d  = step_num;
                quo_d  = step_quo;
                iter_d = iter_q - 1'b1;
                if (iter_q == EXPWIDTH'(1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (out_idle) begin
                    out_load = 1'b1;
                    state_d  = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // ---------------- result assembly ----------------
    logic [WIDTH-1:0] int_q, int_r, fp_word;
    logic [23:0]      mant;
    logic [7:0]       fp_exp;
    logic [22:0]      fp_frac;
    logic             fp_ovf;
    logic [63:0]      result;
`ifdef FP_ROUND_NEAREST_EN
    logic             round_up;
    logic [24:0]      mant_rnd;
`endif

    always_comb begin
        int_q   = div_zero_q ? '1 : (q_neg_q ? -quo_q : quo_q);
        int_r   = div_zero_q ? orig_z_q : (r_neg_q ? -rem_q : rem_q);
        mant    = quo_q[27:4];
        fp_exp  = exp_q;
        fp_frac = mant[22:0];
        fp_ovf  = 1'b0;
`ifdef FP_ROUND_NEAREST_EN
        // quo_q[3] is the guard bit. The lower quotient bits and any
        // remainder form the sticky bit.
        round_up = quo_q[3] & ((|quo_q[2:0]) | (|rem_q) | mant[0]);
        mant_rnd = {1'b0, mant} + {24'd0, round_up};
        fp_frac  = mant_rnd[22:0];
        if (mant_rnd[24]) begin
            fp_frac = '0;
            if (exp_q == 8'd254) begin
                fp_ovf = 1'b1;
            end else begin
                fp_exp = exp_q + 8'd1;
            end
        end
`endif
        case (special_q)
            SP_NAN:  fp_word = 32'h7FC00000;
            SP_INF:  fp_word = {res_sign_q, 8'hFF, 23'd0};
            SP_ZERO: fp_word = {res_sign_q, 31'd0};
            default: fp_word = fp_ovf ? {res_sign_q, 8'hFF, 23'd0}
                                      : {res_sign_q, fp_exp, fp_frac};
        endcase
        result = fp_mode_q ? {fp_word, {WIDTH{1'b0}}} : {int_q, int_r};
    end

    // ---------------- output streamer ----------------
    logic [2:0]  out_cnt_q, out_cnt_d;
    logic [55:0] out_shift_q, out_shift_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        pull_q, pull_d, sign_out_q, sign_out_d;

    // out_cnt_q counts the bytes still to follow the one being presented.
    // A new result may start right after the eighth byte.
    assign out_idle = (out_cnt_q == 3'd0);

    always_comb begin
        out_cnt_d   = out_cnt_q;
        out_shift_d = out_shift_q;
        data_out_d  = 8'd0;
        pull_d      = 1'b0;
        sign_out_d  = 1'b0;
        if (out_load) begin
            data_out_d  = result[7:0];
            out_shift_d = result[63:8];
            out_cnt_d   = 3'd7;
            pull_d      = 1'b1;
            sign_out_d  = result[63];
        end else if (!out_idle) begin
            data_out_d  = out_shift_q[7:0];
            out_shift_d = {8'd0, out_shift_q[55:8]};
            out_cnt_d   = out_cnt_q - 3'd1;
            sign_out_d  = sign_out_q;
        end
    end

    assign data_out_out = data_out_q;
    assign pull_out     = pull_q;
    assign sign_out     = sign_out_q;

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= '0;
            in_shift_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= DIV_IDLE;
            iter_q      <= '0;
            rem_q       <= '0;
            num_q       <= '0;
            den_q       <= '0;
            quo_q       <= '0;
            orig_z_q    <= '0;
            fp_mode_q   <= 1'b0;
            res_sign_q  <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            div_zero_q  <= 1'b0;
            exp_q       <= '0;
            special_q   <= SP_NONE;
            out_cnt_q   <= '0;
            out_shift_q <= '0;
            data_out_q  <= '0;
            pull_q      <= 1'b0;
            sign_out_q  <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            in_shift_q  <= in_shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            iter_q      <= iter_d;
            rem_q       <= rem_d;
            num_q       <= num_d;
            den_q       <= den_d;
            quo_q       <= quo_d;
            orig_z_q    <= orig_z_d;
            fp_mode_q   <= fp_mode_d;
            res_sign_q  <= res_sign_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            div_zero_q  <= div_zero_d;
            exp_q       <= exp_d;
            special_q   <= special_d;
            out_cnt_q   <= out_cnt_d;
            out_shift_q <= out_shift_d;
            data_out_q  <= data_out_d;
            pull_q      <= pull_d;
            sign_out_q  <= sign_out_d;
        end
    end

endmodule

// File: tb/tb_fp_div_serial_top.sv
// ---------------------------------------------------------------------------
// tb_fp_div_serial_top
//
// Self-checking bench for fp_div_serial_top. It drives words byte by byte,
// sometimes with idle gaps. A monitor reassembles the streamed results.
// Each result is compared against a behavioural model of the divider that
// uses plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_fp_div_serial_top;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push_in;
    logic [7:0] data_in_in;
    logic       sign;
    logic       select;
    logic [7:0] data_out_out;
    logic       pull_out;
    logic       sign_out;

    int          check_count = 0;
    int          error_count = 0;
    logic [63:0] got_q[$];
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    fp_div_serial_top dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_in      (push_in),
        .data_in_in   (data_in_in),
        .sign         (sign),
        .select       (select),
        .data_out_out (data_out_out),
        .pull_out     (pull_out),
        .sign_out     (sign_out)
    );

    // Every comparison in the bench goes through this task.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: the divider's rules, computed with plain arithmetic.
    function automatic logic [63:0] refModel(input logic [31:0] z, input logic [31:0] d,
                                             input bit sel, input bit sgn);
        logic [63:0] qv, rv;
        longint      a, b, zm, dm, num, mant, rem;
        int          zi, di, ze, de, e;
        bit          s;
        if (!sel) begin
            if (d == 32'd0) return {32'hFFFFFFFF, z};
            if (sgn) begin
                zi = z;
                di = d;
                a  = zi;
                b  = di;
            end else begin
                a = {32'd0, z};
                b = {32'd0, d};
            end
            qv = a / b;
            rv = a % b;
            return {qv[31:0], rv[31:0]};
        end
        s  = z[31] ^ d[31];
        ze = z[30:23];
        de = d[30:23];
        if ((ze == 255 && z[22:0] != 0) || (de == 255 && d[22:0] != 0))
            return {32'h7FC00000, 32'd0};
        if (de == 0) return {s, 8'hFF, 23'd0, 32'd0};
        if (ze == 0) return {s, 31'd0, 32'd0};
        zm = {1'b1, z[22:0]};
        dm = {1'b1, d[22:0]};
        e  = ze - de + 127;
        if (zm < dm) begin
            zm = zm * 2;
            e  = e - 1;
        end
        if (e > 254) return {s, 8'hFF, 23'd0, 32'd0};
        if (e < 1) return {s, 31'd0, 32'd0};
        num  = zm * 64'd8388608;
        mant = num / dm;
        rem  = num % dm;
`ifdef FP_ROUND_NEAREST_EN
        if ((2 * rem > dm) || ((2 * rem == dm) && (mant % 2 == 1))) mant = mant + 1;
        if (mant == 64'd16777216) begin
            mant = 64'd8388608;
            e    = e + 1;
        end
        if (e > 254) return {s, 8'hFF, 23'd0, 32'd0};
`endif
        qv = mant;
        return {s, e[7:0], qv[22:0], 32'd0};
    endfunction

    // Sends one word as eight bytes. sign/select are randomised except on
    // the eighth byte, where they are sampled.
    task automatic applyStimulus(input logic [31:0] z, input logic [31:0] d,
                                 input bit sel, input bit sgn, input bit gaps);
        logic [63:0] word;
        word = {z, d};
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    push_in    = 1'b0;
                    data_in_in = 8'($urandom);
                    sign       = 1'($urandom);
                    select     = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
            push_in    = 1'b1;
            data_in_in = word[63-8*i -: 8];
            sign       = (i == 7) ? sgn : 1'($urandom);
            select     = (i == 7) ? sel : 1'($urandom);
            @(posedge clk); #1;
        end
        push_in    = 1'b0;
        data_in_in = 8'd0;
        sign       = 1'b0;
        select     = 1'b0;
    endtask

    task automatic waitPull(output int n);
        n = 0;
        while (!pull_out && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic getResult(input string tag, output logic [63:0] r);
        int w;
        w = 0;
        while (got_q.size() == 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        checkOutput({tag, "_arrived"}, 64'(got_q.size() != 0), 64'd1);
        if (got_q.size() != 0) r = got_q.pop_front();
        else r = 'x;
    endtask

    // One word on an idle pipeline: checks latency and the result value.
    task automatic runWord(input string tag, input logic [31:0] z, input logic [31:0] d,
                           input bit sel, input bit sgn, input bit gaps,
                           input logic [63:0] expected);
        int          n;
        logic [63:0] r;
        applyStimulus(z, d, sel, sgn, gaps);
        waitPull(n);
        checkOutput({tag, "_latency_ok"}, 64'(n <= (sel ? 13 : 20)), 64'd1);
        getResult(tag, r);
        checkOutput(tag, r, expected);
    endtask

    task automatic randWord(output logic [31:0] z, output logic [31:0] d,
                            output bit sel, output bit sgn);
        sel = 1'($urandom);
        sgn = 1'($urandom);
        if (sel) begin
            z = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
            d = {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
            if ($urandom_range(0, 5) == 0) z = $urandom;
            if ($urandom_range(0, 5) == 0) d = $urandom;
        end else begin
            z = $urandom;
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(1, 28);
        end
    endtask

    // Output monitor: reassembles streamed bytes into results and checks
    // that the outputs are quiet while nothing is being streamed.
    initial begin
        int          mon_cnt;
        logic [63:0] mon_word;
        logic [7:0]  mon_sign;
        mon_cnt  = 0;
        mon_word = '0;
        mon_sign = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                mon_cnt = 0;
            end else if (pull_out) begin
                mon_word = {56'd0, data_out_out};
                mon_sign = {7'd0, sign_out};
                mon_cnt  = 1;
            end else if (mon_cnt != 0) begin
                mon_word[8*mon_cnt +: 8] = data_out_out;
                mon_sign[mon_cnt]        = sign_out;
                mon_cnt++;
                if (mon_cnt == 8) begin
                    checkOutput("sign_out_held", {56'd0, mon_sign}, {56'd0, {8{mon_word[63]}}});
                    got_q.push_back(mon_word);
                    mon_cnt = 0;
                end
            end else begin
                checkOutput("idle_out", {55'd0, sign_out, data_out_out}, 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] z, d;
        bit          sel, sgn;
        logic [63:0] exp_r, r;
        logic [63:0] exp_list[$];
        int          n;

        rst_n      = 1'b0;
        push_in    = 1'b0;
        data_in_in = 8'd0;
        sign       = 1'b0;
        select     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {54'd0, pull_out, sign_out, data_out_out}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        runWord("fp_1_div_2",    32'h3F800000, 32'h40000000, 1, 0, 0, 64'h3F000000_00000000);
        runWord("fp_neg3",       32'hC0C00000, 32'h40000000, 1, 0, 1, 64'hC0400000_00000000);
        runWord("fp_div_zero",   32'h3F800000, 32'h00000000, 1, 1, 0, 64'h7F800000_00000000);
        runWord("fp_overflow",   32'hCFFF1234, 32'h01234567, 1, 0, 0, 64'hFF800000_00000000);
        runWord("fp_nan",        32'h7FC00001, 32'h3F800000, 1, 0, 0, 64'h7FC00000_00000000);
        runWord("fp_neg_zero",   32'h80000000, 32'h3F800000, 1, 0, 0, 64'h80000000_00000000);
        runWord("fp_underflow",  32'h00800000, 32'h7F000000, 1, 0, 0, 64'h00000000_00000000);
        runWord("fp_min_exp",    32'h00800000, 32'h3F800000, 1, 0, 0, 64'h00800000_00000000);
        runWord("fp_max_exp",    32'h7F7FFFFF, 32'h3F800000, 1, 0, 0, 64'h7F7FFFFF_00000000);
        runWord("fp_exp_255",    32'h7F7FFFFF, 32'h3F000000, 1, 0, 0, 64'h7F800000_00000000);
`ifdef FP_ROUND_NEAREST_EN
        runWord("fp_third",      32'h3F800000, 32'h40400000, 1, 0, 0, 64'h3EAAAAAB_00000000);
`else
        runWord("fp_third",      32'h3F800000, 32'h40400000, 1, 0, 0, 64'h3EAAAAAA_00000000);
`endif
        runWord("int_100_7",     32'd100,      32'd7,        0, 0, 1, 64'h0000000E_00000002);
        runWord("int_s_m7_2",    32'hFFFFFFF9, 32'd2,        0, 1, 0, 64'hFFFFFFFD_FFFFFFFF);
        runWord("int_u_big_2",   32'hFFFFFFF9, 32'd2,        0, 0, 0, 64'h7FFFFFFC_00000001);
        runWord("int_s_min_m1",  32'h80000000, 32'hFFFFFFFF, 0, 1, 0, 64'h80000000_00000000);
        runWord("int_u_div0",    32'd12345,    32'd0,        0, 0, 0, 64'hFFFFFFFF_00003039);
        runWord("int_s_div0",    32'hFFFFFFF9, 32'd0,        0, 1, 0, 64'hFFFFFFFF_FFFFFFF9);
        runWord("int_u_max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 64'h00000001_00000000);

        $display("[TB] random words against model");
        for (int i = 0; i < 30; i++) begin
            randWord(z, d, sel, sgn);
            exp_r = refModel(z, d, sel, sgn);
            runWord(sel ? "rand_fp" : "rand_int", z, d, sel, sgn, 1'($urandom), exp_r);
        end

        $display("[TB] back-to-back words");
        exp_list.delete();
        for (int i = 0; i < 5; i++) begin
            randWord(z, d, sel, sgn);
            exp_list.push_back(refModel(z, d, sel, sgn));
            applyStimulus(z, d, sel, sgn, 0);
        end
        for (int i = 0; i < 5; i++) begin
            getResult("b2b", r);
            checkOutput("b2b_in_order", r, exp_list[i]);
        end

        $display("[TB] reset during output");
        applyStimulus(32'h12345678, 32'd3, 0, 0, 0);
        waitPull(n);
        checkOutput("abort_pull_seen", 64'(pull_out), 64'd1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs", {54'd0, pull_out, sign_out, data_out_out}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_no_result", 64'(got_q.size()), 64'd0);
        runWord("after_reset", 32'd1000, 32'd33, 0, 0, 0, 64'h0000001E_0000000A);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
